// File: rtl/insn_halfword_queue_pkg.sv
// Shared fetch/decode types: halfword entry carried through the instruction buffer,
// buffer sizing constants, and the fetch flush reasons.
package RafiTypes;
   localparam int INSN_BUFFER_DEPTH   = 8;
   localparam int INSN_INT_CODE_WIDTH = 4;

   typedef enum logic [2:0] {
      FlushReason_None,
      FlushReason_Branch,
      FlushReason_Trap,
      FlushReason_InsnBufferFull
   } FlushReason;

   typedef struct packed {
      logic [31:0]                    pc;
      logic [15:0]                    insn;
      logic                           fault;
      logic                           interrupt_valid;
      logic [INSN_INT_CODE_WIDTH-1:0] interrupt_code;
   } insn_hw_entry_t;

   // RVC encoding: any opcode whose two low bits are not 2'b11 is a 16-bit instruction.
   function automatic logic is_compressed(input logic [1:0] op_low);
      return op_low != 2'b11;
   endfunction
endpackage

// File: rtl/insn_halfword_queue_aligner.sv
// Combinational aligner: turns the two halfwords at the queue head into one decode-side
// instruction and reports how many halfwords it consumes.
module insn_halfword_aligner
   import RafiTypes::*;
(
   input  insn_hw_entry_t                 i_h0,
   input  logic [15:0]                    i_h1_insn,
   input  logic                           i_h1_fault,
   input  logic                           i_kill,
   input  logic                           i_have_one,
   input  logic                           i_have_two,
   output logic                           o_valid,
   output logic [31:0]                    o_pc,
   output logic [31:0]                    o_insn,
   output logic                           o_compressed,
   output logic                           o_fault,
   output logic                           o_int_valid,
   output logic [INSN_INT_CODE_WIDTH-1:0] o_int_code,
   output logic [1:0]                     o_n_r
);
   logic w_compressed;
   logic w_single;

   // Faulting or interrupted heads leave alone so the trap is tied to exactly one halfword.
   assign w_compressed = is_compressed(i_h0.insn[1:0]);
   assign w_single     = w_compressed | i_h0.fault | i_h0.interrupt_valid;

   assign o_valid      = !i_kill & i_have_one & (w_single | i_have_two);
   assign o_pc         = i_h0.pc;
   assign o_insn       = w_single ? {16'b0, i_h0.insn} : {i_h1_insn, i_h0.insn};
   assign o_compressed = w_compressed;
   assign o_fault      = i_h0.fault | (!w_compressed & i_h1_fault);
   assign o_int_valid  = i_h0.interrupt_valid;
   assign o_int_code   = i_h0.interrupt_code;
   assign o_n_r        = w_single ? 2'd1 : 2'd2;
endmodule

// File: rtl/insn_halfword_queue.sv
// Instruction halfword queue between fetch and decode: circular storage with head/tail
// pointers and an occupancy count; decode sees one aligned instruction per cycle.
module insn_halfword_queue
   import RafiTypes::*;
#(
   parameter int DEPTH          = INSN_BUFFER_DEPTH,
   parameter int INT_CODE_WIDTH = INSN_INT_CODE_WIDTH
)(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic                      write_low,
   input  logic                      write_high,
   input  insn_hw_entry_t            write_entry_low,
   input  insn_hw_entry_t            write_entry_high,
   output logic [$clog2(DEPTH):0]    writable_count,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [31:0]               out_pc,
   output logic [31:0]               out_insn,
   output logic                      out_compressed,
   output logic                      out_fault,
   output logic                      out_int_valid,
   output logic [INT_CODE_WIDTH-1:0] out_int_code
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   insn_hw_entry_t r_mem [DEPTH];
   logic [PW-1:0]  r_head;
   logic [PW-1:0]  r_tail;
   logic [CW-1:0]  r_count;
   logic [CW-1:0]  r_writable_count;

   logic [1:0]     w_n_w;
   logic [1:0]     w_n_r;
   logic           w_wr_en;
   logic           w_rd_en;
   logic           w_kill;
   logic [CW-1:0]  w_count_next;
   logic [PW-1:0]  w_head_p1;
   logic [PW-1:0]  w_tail_p1;
   insn_hw_entry_t w_h0;
   insn_hw_entry_t w_h1;

   // A low-only write is malformed and counts as zero entries; oversize writes are dropped whole.
   assign w_n_w     = write_high ? (write_low ? 2'd2 : 2'd1) : 2'd0;
   assign w_wr_en   = (w_n_w != 2'd0) && (CW'(w_n_w) <= r_writable_count);
   assign w_kill    = rst | flush;
   assign w_rd_en   = out_valid & out_ready;
   assign w_head_p1 = r_head + PW'(1);
   assign w_tail_p1 = r_tail + PW'(1);
   assign w_h0      = r_mem[r_head];
   assign w_h1      = r_mem[w_head_p1];

   assign w_count_next = r_count + (w_wr_en ? CW'(w_n_w) : CW'(0))
                                 - (w_rd_en ? CW'(w_n_r) : CW'(0));

   insn_halfword_aligner u_aligner (
      .i_h0         (w_h0),
      .i_h1_insn    (w_h1.insn),
      .i_h1_fault   (w_h1.fault),
      .i_kill       (w_kill),
      .i_have_one   (r_count != CW'(0)),
      .i_have_two   (r_count >= CW'(2)),
      .o_valid      (out_valid),
      .o_pc         (out_pc),
      .o_insn       (out_insn),
      .o_compressed (out_compressed),
      .o_fault      (out_fault),
      .o_int_valid  (out_int_valid),
      .o_int_code   (out_int_code),
      .o_n_r        (w_n_r)
   );

   always_ff @(posedge clk) begin
      if (w_kill) begin
         r_head           <= '0;
         r_tail           <= '0;
         r_count          <= '0;
         r_writable_count <= CW'(DEPTH);
      end else begin
         if (w_wr_en) r_tail <= r_tail + PW'(w_n_w);
         if (w_rd_en) r_head <= r_head + PW'(w_n_r);
         r_count          <= w_count_next;
         r_writable_count <= CW'(DEPTH) - w_count_next;
      end
   end

   // Storage carries no reset; entries are only observed while out_valid is high.
   always_ff @(posedge clk) begin
      if (!w_kill && w_wr_en) begin
         if (write_low) begin
            r_mem[r_tail]    <= write_entry_low;
            r_mem[w_tail_p1] <= write_entry_high;
         end else begin
            r_mem[r_tail]    <= write_entry_high;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!w_kill) begin
         assert (!(write_low && !write_high))
            else $warning("insn_halfword_queue: write_low without write_high ignored");
         assert (w_n_w == 2'd0 || w_wr_en)
            else $warning("insn_halfword_queue: write of %0d entries dropped, %0d free", w_n_w, r_writable_count);
      end
   end

   assign writable_count = r_writable_count;
endmodule

// File: tb/tb_insn_halfword_queue.sv
// Scenario bench for insn_halfword_queue: expected decode outputs are queued when
// halfwords are written and compared as the queue hands them to decode.
module tb_insn_halfword_queue;
   import RafiTypes::*;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] insn;
      logic        comp;
      logic        fault;
      logic        iv;
      logic [3:0]  code;
   } out_rec_t;
   localparam int RW = $bits(out_rec_t);

   logic           clk = 1'b0;
   logic           rst, flush, write_low, write_high, out_ready;
   insn_hw_entry_t write_entry_low, write_entry_high;
   logic [3:0]     writable_count;
   logic           out_valid, out_compressed, out_fault, out_int_valid;
   logic [31:0]    out_pc, out_insn;
   logic [3:0]     out_int_code;

   logic [RW-1:0]  exp_q[$];
   int             checks = 0;
   int             errors = 0;

   always #5 clk = ~clk;

   insn_halfword_queue #(.DEPTH(8), .INT_CODE_WIDTH(4)) dut (
      .clk              (clk),
      .rst              (rst),
      .flush            (flush),
      .write_low        (write_low),
      .write_high       (write_high),
      .write_entry_low  (write_entry_low),
      .write_entry_high (write_entry_high),
      .writable_count   (writable_count),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_pc           (out_pc),
      .out_insn         (out_insn),
      .out_compressed   (out_compressed),
      .out_fault        (out_fault),
      .out_int_valid    (out_int_valid),
      .out_int_code     (out_int_code)
   );

   function automatic insn_hw_entry_t mkx(input logic [31:0] pc, input logic [15:0] insn,
                                          input logic f, input logic iv, input logic [3:0] code);
      insn_hw_entry_t e;
      e.pc = pc; e.insn = insn; e.fault = f; e.interrupt_valid = iv; e.interrupt_code = code;
      return e;
   endfunction

   function automatic insn_hw_entry_t mk(input logic [31:0] pc, input logic [15:0] insn);
      return mkx(pc, insn, 1'b0, 1'b0, 4'd0);
   endfunction

   function automatic logic [RW-1:0] rec(input logic [31:0] pc, input logic [31:0] insn,
                                         input logic comp, input logic f, input logic iv,
                                         input logic [3:0] code);
      return {pc, insn, comp, f, iv, code};
   endfunction

   function automatic logic [RW-1:0] observed();
      return {out_pc, out_insn, out_compressed, out_fault, out_int_valid, out_int_code};
   endfunction

   // Inputs change at the falling edge; outputs are read 1 time unit later.
   task automatic drive(input logic wl, input logic wh, input insn_hw_entry_t el,
                        input insn_hw_entry_t eh, input logic rdy, input logic fl);
      write_low = wl; write_high = wh; write_entry_low = el; write_entry_high = eh;
      out_ready = rdy; flush = fl;
      #1;
   endtask

   task automatic idle(input logic rdy);
      drive(1'b0, 1'b0, '0, '0, rdy, 1'b0);
   endtask

   task automatic next_cycle();
      @(negedge clk);
   endtask

   task automatic test_reset();
      idle(1'b0);
      checks++;
      if (writable_count !== 4'd8) begin errors++; $display("FAIL reset_writable got=%0d exp=8", writable_count); end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
      next_cycle();
   endtask

   task automatic test_basic();
      logic [RW-1:0] e;
      drive(1'b1, 1'b1, mk(32'h100, 16'h0513), mk(32'h102, 16'h0045), 1'b0, 1'b0);
      exp_q.push_back(rec(32'h100, 32'h00450513, 1'b0, 1'b0, 1'b0, 4'd0));
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_latency got=%b exp=0", out_valid); end
      next_cycle();
      idle(1'b1);
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
      else begin
         e = exp_q.pop_front(); checks++;
         if (observed() !== e) begin errors++; $display("FAIL basic_out got=%h exp=%h", observed(), e); end
      end
      checks++;
      if (writable_count !== 4'd6) begin errors++; $display("FAIL basic_writable got=%0d exp=6", writable_count); end
      next_cycle();
      idle(1'b0);
      checks++;
      if (out_valid !== 1'b0 || writable_count !== 4'd8) begin
         errors++; $display("FAIL basic_empty valid=%b writable=%0d exp valid=0 writable=8", out_valid, writable_count);
      end
      next_cycle();
      exp_q.delete();
   endtask

   task automatic test_compressed();
      logic [RW-1:0] e;
      drive(1'b1, 1'b1, mk(32'h200, 16'h4501), mk(32'h202, 16'h4585), 1'b1, 1'b0);
      exp_q.push_back(rec(32'h200, 32'h00004501, 1'b1, 1'b0, 1'b0, 4'd0));
      exp_q.push_back(rec(32'h202, 32'h00004585, 1'b1, 1'b0, 1'b0, 4'd0));
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL comp_latency got=%b exp=0", out_valid); end
      next_cycle();
      for (int k = 0; k < 2; k++) begin
         idle(1'b1);
         checks++;
         if (out_valid !== 1'b1) begin errors++; $display("FAIL comp_valid%0d got=%b exp=1", k, out_valid); end
         else begin
            e = exp_q.pop_front(); checks++;
            if (observed() !== e) begin errors++; $display("FAIL comp_out%0d got=%h exp=%h", k, observed(), e); end
         end
         next_cycle();
      end
      idle(1'b0);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL comp_empty got=%b exp=0", out_valid); end
      next_cycle();
      exp_q.delete();
   endtask

   task automatic test_straddle();
      logic [RW-1:0] e;
      drive(1'b0, 1'b1, '0, mk(32'h1FE, 16'h0513), 1'b1, 1'b0);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL strad_empty got=%b exp=0", out_valid); end
      next_cycle();
      drive(1'b1, 1'b1, mk(32'h200, 16'h0045), mk(32'h202, 16'h4501), 1'b1, 1'b0);
      exp_q.push_back(rec(32'h1FE, 32'h00450513, 1'b0, 1'b0, 1'b0, 4'd0));
      exp_q.push_back(rec(32'h202, 32'h00004501, 1'b1, 1'b0, 1'b0, 4'd0));
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL strad_partial got=%b exp=0", out_valid); end
      next_cycle();
      for (int k = 0; k < 2; k++) begin
         idle(1'b1);
         checks++;
         if (out_valid !== 1'b1) begin errors++; $display("FAIL strad_valid%0d got=%b exp=1", k, out_valid); end
         else begin
            e = exp_q.pop_front(); checks++;
            if (observed() !== e) begin errors++; $display("FAIL strad_out%0d got=%h exp=%h", k, observed(), e); end
         end
         next_cycle();
      end
      idle(1'b0);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL strad_empty2 got=%b exp=0", out_valid); end
      next_cycle();
      exp_q.delete();
   endtask

   task automatic test_full_wrap();
      logic [RW-1:0]  e;
      insn_hw_entry_t lo [5];
      insn_hw_entry_t hi [5];
      lo[0] = mk(32'h300, 16'h0293); hi[0] = mk(32'h302, 16'h1234);
      lo[1] = mk(32'h304, 16'h4505); hi[1] = mk(32'h306, 16'h4609);
      lo[2] = mk(32'h308, 16'h0313); hi[2] = mk(32'h30A, 16'h5678);
      lo[3] = mk(32'h30C, 16'h8082); hi[3] = mk(32'h30E, 16'h4701);
      lo[4] = mk(32'h400, 16'h4501); hi[4] = mk(32'h402, 16'h4505);
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 1'b1, lo[k], hi[k], 1'b0, 1'b0);
         checks++;
         if (writable_count !== 4'(8 - 2 * k)) begin
            errors++; $display("FAIL full_writable%0d got=%0d exp=%0d", k, writable_count, 8 - 2 * k);
         end
         next_cycle();
      end
      exp_q.push_back(rec(32'h300, 32'h12340293, 1'b0, 1'b0, 1'b0, 4'd0));
      exp_q.push_back(rec(32'h304, 32'h00004505, 1'b1, 1'b0, 1'b0, 4'd0));
      exp_q.push_back(rec(32'h306, 32'h00004609, 1'b1, 1'b0, 1'b0, 4'd0));
      exp_q.push_back(rec(32'h308, 32'h56780313, 1'b0, 1'b0, 1'b0, 4'd0));
      exp_q.push_back(rec(32'h30C, 32'h00008082, 1'b1, 1'b0, 1'b0, 4'd0));
      exp_q.push_back(rec(32'h30E, 32'h00004701, 1'b1, 1'b0, 1'b0, 4'd0));
      drive(1'b1, 1'b1, lo[4], hi[4], 1'b0, 1'b0);
      checks++;
      if (writable_count !== 4'd0 || out_valid !== 1'b1) begin
         errors++; $display("FAIL full_state writable=%0d valid=%b exp writable=0 valid=1", writable_count, out_valid);
      end
      next_cycle();
      idle(1'b0);
      checks++;
      if (writable_count !== 4'd0) begin errors++; $display("FAIL full_drop got=%0d exp=0", writable_count); end
      for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
         idle(1'b1);
         if (out_valid) begin
            e = exp_q.pop_front(); checks++;
            if (observed() !== e) begin errors++; $display("FAIL full_drain got=%h exp=%h", observed(), e); end
         end
         next_cycle();
      end
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL full_drain_timeout left=%0d exp=0", exp_q.size()); end
      idle(1'b0);
      checks++;
      if (writable_count !== 4'd8 || out_valid !== 1'b0) begin
         errors++; $display("FAIL full_empty writable=%0d valid=%b exp writable=8 valid=0", writable_count, out_valid);
      end
      next_cycle();
      exp_q.delete();
   endtask

   task automatic test_flush();
      logic [RW-1:0] e;
      drive(1'b1, 1'b1, mk(32'h500, 16'h0513), mk(32'h502, 16'h0045), 1'b0, 1'b0);
      next_cycle();
      drive(1'b1, 1'b1, mk(32'h504, 16'h4501), mk(32'h506, 16'h4585), 1'b1, 1'b1);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
      next_cycle();
      idle(1'b1);
      checks++;
      if (out_valid !== 1'b0 || writable_count !== 4'd8) begin
         errors++; $display("FAIL flush_after valid=%b writable=%0d exp valid=0 writable=8", out_valid, writable_count);
      end
      next_cycle();
      drive(1'b1, 1'b1, mk(32'h600, 16'h4501), mk(32'h602, 16'h4585), 1'b0, 1'b0);
      exp_q.push_back(rec(32'h600, 32'h00004501, 1'b1, 1'b0, 1'b0, 4'd0));
      exp_q.push_back(rec(32'h602, 32'h00004585, 1'b1, 1'b0, 1'b0, 4'd0));
      next_cycle();
      for (int c = 0; c < 10 && exp_q.size() != 0; c++) begin
         idle(1'b1);
         if (out_valid) begin
            e = exp_q.pop_front(); checks++;
            if (observed() !== e) begin errors++; $display("FAIL flush_refill got=%h exp=%h", observed(), e); end
         end
         next_cycle();
      end
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL flush_timeout left=%0d exp=0", exp_q.size()); end
      exp_q.delete();
   endtask

   task automatic test_fault();
      logic [RW-1:0] e;
      drive(1'b1, 1'b1, mkx(32'h700, 16'hFFFF, 1'b1, 1'b0, 4'd0), mk(32'h702, 16'h4501), 1'b0, 1'b0);
      next_cycle();
      drive(1'b1, 1'b1, mk(32'h704, 16'h0513), mkx(32'h706, 16'h0045, 1'b1, 1'b0, 4'd0), 1'b0, 1'b0);
      next_cycle();
      drive(1'b1, 1'b1, mkx(32'h708, 16'h0513, 1'b0, 1'b1, 4'd5), mk(32'h70A, 16'h4501), 1'b0, 1'b0);
      exp_q.push_back(rec(32'h700, 32'h0000FFFF, 1'b0, 1'b1, 1'b0, 4'd0));
      exp_q.push_back(rec(32'h702, 32'h00004501, 1'b1, 1'b0, 1'b0, 4'd0));
      exp_q.push_back(rec(32'h704, 32'h00450513, 1'b0, 1'b1, 1'b0, 4'd0));
      exp_q.push_back(rec(32'h708, 32'h00000513, 1'b0, 1'b0, 1'b1, 4'd5));
      exp_q.push_back(rec(32'h70A, 32'h00004501, 1'b1, 1'b0, 1'b0, 4'd0));
      next_cycle();
      for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
         idle(1'b1);
         if (out_valid) begin
            e = exp_q.pop_front(); checks++;
            if (observed() !== e) begin errors++; $display("FAIL fault_out got=%h exp=%h", observed(), e); end
         end
         next_cycle();
      end
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL fault_timeout left=%0d exp=0", exp_q.size()); end
      exp_q.delete();
   endtask

   task automatic test_reset_with_data();
      drive(1'b1, 1'b1, mk(32'h800, 16'h4501), mk(32'h802, 16'h4585), 1'b0, 1'b0);
      next_cycle();
      idle(1'b0);
      checks++;
      if (out_valid !== 1'b1 || writable_count !== 4'd6) begin
         errors++; $display("FAIL rstd_hold valid=%b writable=%0d exp valid=1 writable=6", out_valid, writable_count);
      end
      rst = 1'b1;
      idle(1'b1);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rstd_valid got=%b exp=0", out_valid); end
      next_cycle();
      rst = 1'b0;
      idle(1'b1);
      checks++;
      if (out_valid !== 1'b0 || writable_count !== 4'd8) begin
         errors++; $display("FAIL rstd_after valid=%b writable=%0d exp valid=0 writable=8", out_valid, writable_count);
      end
      next_cycle();
   endtask

   task automatic test_random();
      logic [RW-1:0]  e;
      logic [31:0]    pc;
      pc = 32'h1000;
      for (int c = 0; c < 80; c++) begin
         logic           do_w;
         logic           rdy;
         logic [15:0]    i0;
         logic [15:0]    i1;
         do_w = (writable_count >= 4'd2) && ($urandom_range(0, 2) != 0);
         rdy  = ($urandom_range(0, 3) != 0);
         i0 = 16'($urandom_range(0, 65535)); i0[1:0] = 2'($urandom_range(0, 2));
         i1 = 16'($urandom_range(0, 65535)); i1[1:0] = 2'($urandom_range(0, 2));
         if (do_w) begin
            drive(1'b1, 1'b1, mk(pc, i0), mk(pc + 32'd2, i1), rdy, 1'b0);
         end else begin
            idle(rdy);
         end
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL rand_unexpected got=%h exp=none", observed());
            end else begin
               e = exp_q.pop_front();
               if (observed() !== e) begin errors++; $display("FAIL rand_out got=%h exp=%h", observed(), e); end
            end
         end
         if (do_w) begin
            exp_q.push_back(rec(pc, {16'b0, i0}, 1'b1, 1'b0, 1'b0, 4'd0));
            exp_q.push_back(rec(pc + 32'd2, {16'b0, i1}, 1'b1, 1'b0, 1'b0, 4'd0));
            pc = pc + 32'd4;
         end
         next_cycle();
      end
      for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
         idle(1'b1);
         if (out_valid) begin
            e = exp_q.pop_front(); checks++;
            if (observed() !== e) begin errors++; $display("FAIL rand_drain got=%h exp=%h", observed(), e); end
         end
         next_cycle();
      end
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL rand_timeout left=%0d exp=0", exp_q.size()); end
      exp_q.delete();
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; write_low = 1'b0; write_high = 1'b0;
      write_entry_low = '0; write_entry_high = '0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      test_reset();
      test_basic();
      test_compressed();
      test_straddle();
      test_full_wrap();
      test_flush();
      test_fault();
      test_reset_with_data();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
